// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative MULT/MULTU/DIV/DIVU engine that owns HI/LO.
// Build option: MULDIV_DIV_EN compiles in the restoring divider datapath.
//
// Ports:
//   clk, reset (async, active-low)
//   startE, opE, srcaE, srcbE : muldiv op issued from EX
//   hiloreadD                 : MFHI/MFLO in decode
//   mthiE, mtloE              : MTHI/MTLO in EX (data = srcaE)
//   hi, lo                    : architectural HI/LO
//   busy, done, stallD        : sequence status and hazard stall request
//   divzero                   : sticky divide-by-zero / illegal-op flag
module muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             startE,
    input  logic [1:0]       opE,
    input  logic [WIDTH-1:0] srcaE,
    input  logic [WIDTH-1:0] srcbE,
    input  logic             hiloreadD,
    input  logic             mthiE,
    input  logic             mtloE,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             stallD,
    output logic             divzero
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;

    localparam logic [1:0] MODE_MUL  = 2'd0;
    localparam logic [1:0] MODE_NONE = 2'd3;
`ifdef MULDIV_DIV_EN
    localparam logic [1:0] MODE_DIV  = 2'd1;
    localparam logic [1:0] MODE_RAW  = 2'd2;
`endif

    logic [1:0]         state;
    logic [1:0]         mode;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   operand;
    logic               negQ;
`ifdef MULDIV_DIV_EN
    logic               negR;
`endif

    logic               signedOp;
    logic [WIDTH-1:0]   absA;
    logic [WIDTH-1:0]   absB;
    logic [WIDTH:0]     mulSum;
    logic [2*WIDTH-1:0] mulNext;
    logic [2*WIDTH-1:0] calcNext;
    logic [2*WIDTH-1:0] mulRes;
`ifdef MULDIV_DIV_EN
    logic [WIDTH+1:0]   diff;
    logic [2*WIDTH-1:0] divNext;
    logic [WIDTH-1:0]   quotRes;
    logic [WIDTH-1:0]   remRes;
`endif

    assign stallD = busy & (hiloreadD | startE | mthiE | mtloE);

    always_comb begin
        signedOp = ~opE[0];
        absA = (signedOp & srcaE[WIDTH-1]) ? -srcaE : srcaE;
        absB = (signedOp & srcbE[WIDTH-1]) ? -srcbE : srcbE;

        // Shift-add: add multiplicand into the upper half, keep the carry
        // as the new top bit after the right shift.
        mulSum = {1'b0, acc[2*WIDTH-1:WIDTH]}
               + (acc[0] ? {1'b0, operand} : '0);
        mulNext = {mulSum, acc[WIDTH-1:1]};
        mulRes = negQ ? -acc : acc;
        calcNext = mulNext;

`ifdef MULDIV_DIV_EN
        // The shifted remainder can reach WIDTH+1 bits, so trial-subtract
        // with two guard bits; the MSB then reads as the borrow.
        diff = {1'b0, acc[2*WIDTH-1:WIDTH-1]} - {2'b00, operand};
        divNext = diff[WIDTH+1] ? {acc[2*WIDTH-2:0], 1'b0}
                                : {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        quotRes = negQ ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        remRes = negR ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        if (mode == MODE_DIV) begin
            calcNext = divNext;
        end
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            mode    <= MODE_NONE;
            cnt     <= '0;
            acc     <= '0;
            operand <= '0;
            negQ    <= 1'b0;
`ifdef MULDIV_DIV_EN
            negR    <= 1'b0;
`endif
            hi      <= '0;
            lo      <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            divzero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (mthiE) hi <= srcaE;
                    if (mtloE) lo <= srcaE;
                    if (startE) begin
                        busy <= 1'b1;
                        cnt  <= '0;
                        if (opE[1]) begin
`ifdef MULDIV_DIV_EN
                            if (srcbE == '0) begin
                                // Skip iteration; FIX copies acc verbatim.
                                acc     <= {srcaE, {WIDTH{1'b1}}};
                                mode    <= MODE_RAW;
                                divzero <= 1'b1;
                                state   <= FIX;
                            end else begin
                                acc     <= {{WIDTH{1'b0}}, absA};
                                operand <= absB;
                                negQ    <= signedOp & (srcaE[WIDTH-1] ^ srcbE[WIDTH-1]);
                                negR    <= signedOp & srcaE[WIDTH-1];
                                mode    <= MODE_DIV;
                                state   <= CALC;
                            end
`else
                            // No divider: flag the op, leave HI/LO alone.
                            mode    <= MODE_NONE;
                            divzero <= 1'b1;
                            state   <= FIX;
`endif
                        end else begin
                            acc     <= {{WIDTH{1'b0}}, absB};
                            operand <= absA;
                            negQ    <= signedOp & (srcaE[WIDTH-1] ^ srcbE[WIDTH-1]);
                            mode    <= MODE_MUL;
                            state   <= CALC;
                        end
                    end
                end
                CALC: begin
                    acc <= calcNext;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) state <= FIX;
                end
                FIX: begin
                    case (mode)
                        MODE_MUL: begin
                            hi <= mulRes[2*WIDTH-1:WIDTH];
                            lo <= mulRes[WIDTH-1:0];
                        end
`ifdef MULDIV_DIV_EN
                        MODE_DIV: begin
                            hi <= remRes;
                            lo <= quotRes;
                        end
                        MODE_RAW: begin
                            hi <= acc[2*WIDTH-1:WIDTH];
                            lo <= acc[WIDTH-1:0];
                        end
`endif
                        default: ;
                    endcase
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Iterative multiply/divide controller owning the HI/LO register pair of the pipelined MIPS core. Accepts MULT/MULTU/DIV/DIVU from the execute stage and runs a 32-iteration shift-add or restoring-divide sequence. It services MTHI/MTLO writes and MFHI/MFLO reads. It raises a stall request toward the hazard unit while a result is pending.

## Interface
- WIDTH, 32, operand and HI/LO width; iteration count equals WIDTH.
- clk  in  1  core clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low; clears all state.
- startE  in  1  muldiv instruction in EX this cycle.
- opE  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- srcaE  in  WIDTH  rs operand (multiplicand/dividend).
- srcbE  in  WIDTH  rt operand (multiplier/divisor).
- hiloreadD  in  1  MFHI/MFLO in decode.
- mthiE, mtloE  in  1  MTHI/MTLO in EX; data taken from srcaE.
- hi, lo  out  WIDTH  architectural HI/LO.
- busy  out  1  sequence in progress.
- done  out  1  one-cycle pulse when a result is written to HI/LO.
- stallD  out  1  stall request: busy & (hiloreadD | startE | mthiE | mtloE).
- divzero  out  1  sticky flag; set when a DIV/DIVU is issued with srcbE==0; cleared by reset only.

## Operation
- State machine with three states:
  - IDLE: accepts start, MTHI, MTLO.
  - CALC: counter 0..WIDTH-1.
  - FIX: sign correction and HI/LO write.
- IDLE + startE: latch operands and op, counter <= 0, go to CALC.
  - Signed ops latch the absolute values plus the sign bits.
- Multiply: 2*WIDTH-bit accumulator. Per CALC cycle: if multiplier LSB then add the multiplicand to the upper half, then shift right 1.
- Divide: restoring. Per cycle:
  - shift remainder:quotient left 1;
  - trial-subtract the divisor;
  - keep the difference and set quotient LSB if non-negative.
- CALC with counter==WIDTH-1: go to FIX.
- FIX applies signs, writes results, returns to IDLE, pulses done.
  - MULT: 2WIDTH product negated if sa^sb. HI=upper, LO=lower.
  - DIV: quotient negated if sa^sb; remainder negated if sa. LO=quotient, HI=remainder.
  - Unsigned ops skip correction.
  - 0x80000000 / -1 yields LO=0x80000000, HI=0 (natural wrap).
- Divide by zero: no CALC.
  - IDLE -> FIX directly.
  - LO=all-ones, HI=dividend (unmodified srcaE).
  - divzero set.
- MTHI/MTLO in IDLE: hi/lo <= srcaE at next edge; no done pulse.
- startE/mthiE/mtloE while busy: ignored by this block; stallD is asserted so the hazard unit holds them.
- Reset mid-sequence: immediate return to IDLE.
  - hi=lo=0, busy=0, done=0, divzero=0.
  - Partial result discarded.

## Timing
- Reset values of all outputs are 0. stallD evaluates to 0 during reset.
- Start sampled at edge E0. busy=1 after E0.
- CALC occupies edges E1..E32. FIX at E33.
- After E33: hi/lo hold the result, done=1 for one cycle, busy=0.
- MFHI/MFLO issued the cycle after done reads the new value without stall.
- Divide by zero: FIX at E1; result and done after E1.
- busy is registered. stallD is combinational from busy and the D/EX inputs.
- Back-to-back: startE in the cycle done is high is accepted (state is IDLE).

## Configuration
- MULDIV_DIV_EN defined: divider datapath and DIV/DIVU support compiled in, as specified above.
- MULDIV_DIV_EN undefined: divider logic removed.
  - DIV/DIVU go IDLE -> FIX in one cycle with hi/lo unchanged.
  - done still pulses.
  - divzero is set for every DIV/DIVU, serving as an illegal-op flag.

## Test plan
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> after 33 edges HI=0xFFFFFFFE, LO=0x00000001; done pulses once; busy high exactly 33 cycles.
- MULT -7 x 3 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB; DIV -7 / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU 100 / 0 -> after 1 edge LO=0xFFFFFFFF, HI=100, divzero=1, no CALC cycles.
- MULT issued, hiloreadD held high -> stallD=1 every busy cycle, 0 the cycle after done; MTLO 0x1234 in IDLE -> lo=0x1234, hi unchanged.
- DIVU 1000 / 7 started, reset asserted at CALC cycle 10 -> all outputs 0 asynchronously; new DIVU after release gives LO=142, HI=6.
- With MULDIV_DIV_EN undefined: DIV 10 / 2 -> hi/lo unchanged, done after 1 edge, divzero=1.
